vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning the expected active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning the expected active lines per frame.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, meaning the number of consecutive good frames needed to lock (range 1..7).
REQ-004 SHALL have port CLK  in  1  pixel clock (25 MHz); the block's only clock.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port HSYNC  in  1  horizontal sync, active-low pulse.
REQ-007 SHALL have port VSYNC  in  1  vertical sync, active-low pulse.
REQ-008 SHALL have port IMG  in  1  visible-area flag.
REQ-009 SHALL have ports r_in, g_in, b_in  in  8 each  incoming pixel colour.
REQ-010 SHALL have ports r_out, g_out, b_out  out  8 each  registered pixel colour.
REQ-011 SHALL have port X  out  10  recovered column; port Y  out  9  recovered row.
REQ-012 SHALL have port pix_valid  out  1  X/Y/rgb outputs describe a visible pixel.
REQ-013 SHALL have ports line_start and frame_start  out  1 each  one-cycle pulses.
REQ-014 SHALL have port locked  out  1  timing stable; port sync_err  out  1  one-cycle error pulse.
REQ-015 SHALL have ports h_total  out  10  and v_total  out  10  measured totals.

Function
REQ-016 SHALL register HSYNC/VSYNC once and detect falling edges against the previous registered value; an edge on the first cycle after reset does not count.
REQ-017 SHALL assert line_start one cycle after HSYNC falling edge; frame_start one cycle after VSYNC falling edge.
REQ-018 SHALL reset the column counter on each HSYNC edge, and increment it on each cycle with IMG=1, saturating at 1023.
REQ-019 SHALL reset the row counter on each VSYNC edge, and increment it on each HSYNC edge ending a line with at least one IMG=1 cycle, saturating at 511.
REQ-020 SHALL output X, Y, pix_valid, rgb with a latency of one cycle from sampling IMG/rgb; rgb_out SHALL be 0 when IMG=0.
REQ-021 SHALL treat a line as good when its IMG=1 count equals H_ACTIVE, and a frame as good when all of its lines are good and it holds exactly V_ACTIVE active lines.
REQ-022 SHALL implement an FSM with states UNLOCKED, MEASURE and LOCKED.
REQ-023 In UNLOCKED, the FSM SHALL go to MEASURE on the first VSYNC edge and clear the good-frame counter.
REQ-024 In MEASURE, at each VSYNC edge a good frame SHALL increment the counter, with LOCKED entered when it reaches LOCK_FRAMES; a bad frame SHALL clear the counter and stay in MEASURE.
REQ-025 In LOCKED, any bad line SHALL pulse sync_err and go to UNLOCKED on the cycle after that line's closing HSYNC edge, and a bad frame SHALL do the same at VSYNC.
REQ-026 When HSYNC and VSYNC edges coincide, the FSM SHALL close the line first, then close the frame; the row counter SHALL end at 0.
REQ-027 SHALL drive locked=1 only in the LOCKED state.

Reset
REQ-028 While reset=0, every output, counter and sync register SHALL be 0 and the FSM SHALL be UNLOCKED.
REQ-029 On reset mid-frame, the partial frame SHALL be discarded; measurement SHALL restart at the next VSYNC edge.

Configuration
REQ-030 With VGA_DEC_MEASURE_EN defined, h_total SHALL hold the cycle count between the last two HSYNC edges, saturating at 1023.
REQ-031 With VGA_DEC_MEASURE_EN defined, v_total SHALL hold the line count between the last two VSYNC edges, saturating at 1023; both SHALL update at the respective edge.
REQ-032 Without VGA_DEC_MEASURE_EN, h_total and v_total SHALL be tied to 0 and their counters SHALL not be synthesised.

Verification
REQ-033 Standard 640x480 timing (800x525), 3 frames after reset: locked=1 one cycle after the 3rd VSYNC edge; h_total=800, v_total=525 (macro on).
REQ-034 First visible pixel of a locked frame with rgb=0x12/0x34/0x56: next cycle X=0, Y=0, pix_valid=1, rgb_out=0x12/0x34/0x56.
REQ-035 Locked stream with one line holding 639 IMG cycles: sync_err one pulse, locked=0 after that line's HSYNC; relock after 2 good frames.
REQ-036 Frame of 479 active lines during MEASURE: good-frame count cleared; no lock until 2 further good frames.
REQ-037 reset driven 0 at line 200 while locked: all outputs 0 immediately; after release, locked stays 0 until 2 complete good frames.
REQ-038 IMG=0 with rgb_in=0xFF: rgb_out=0 and pix_valid=0 next cycle.

Source files
------------

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_decoder
// Description : Recovers pixel coordinates from a VGA-style HSYNC/VSYNC/IMG
//               stream, registers the colour, and tracks timing lock.
//               Optional macro VGA_DEC_MEASURE_EN adds h_total/v_total
//               period measurement (tied to 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       HSYNC,
  input  logic       VSYNC,
  input  logic       IMG,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic [9:0] X,
  output logic [8:0] Y,
  output logic       pix_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err,
  output logic [9:0] h_total,
  output logic [9:0] v_total
);

  localparam logic [9:0] c_h_active    = 10'(H_ACTIVE);
  localparam logic [8:0] c_v_active    = 9'(V_ACTIVE);
  localparam logic [2:0] c_lock_frames = 3'(LOCK_FRAMES);
  localparam logic [9:0] c_col_max     = 10'h3FF;
  localparam logic [8:0] c_row_max     = 9'h1FF;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_MEASURE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_hs;
  logic       r_hs_prev;
  logic       r_vs;
  logic       r_vs_prev;
  logic [9:0] r_col;
  logic [8:0] r_row;
  logic       r_frame_bad;
  logic [2:0] r_good_cnt;
  logic [2:0] w_good_next;
  logic [2:0] w_good_inc;
  logic       w_err;
  logic       w_h_edge;
  logic       w_v_edge;
  logic       w_line_active;
  logic       w_line_bad;
  logic [9:0] w_col_base;
  logic [8:0] w_row_closed;
  logic       w_frame_bad;

  // Reset values of 0 on both stages mean no edge can appear on the first
  // cycle after reset, whatever level the sync lines sit at.
  assign w_h_edge      = r_hs_prev & ~r_hs;
  assign w_v_edge      = r_vs_prev & ~r_vs;
  // A line with no IMG cycles is blanking and is never judged.
  assign w_line_active = (r_col != 10'd0);
  assign w_line_bad    = w_line_active && (r_col != c_h_active);
  // An IMG cycle that coincides with the HSYNC edge belongs to the new line.
  assign w_col_base    = w_h_edge ? 10'd0 : r_col;
  // Row count with the closing line included, so coincident edges close
  // the line before the frame.
  assign w_row_closed  = (w_h_edge && w_line_active && (r_row != c_row_max)) ?
                         r_row + 9'd1 : r_row;
  assign w_frame_bad   = r_frame_bad || (w_h_edge && w_line_bad) ||
                         (w_row_closed != c_v_active);
  assign w_good_inc    = r_good_cnt + 3'd1;
  assign locked        = (r_state == ST_LOCKED);

  // Sync input registers and previous-value stage for edge detection.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_hs      <= 1'b0;
      r_hs_prev <= 1'b0;
      r_vs      <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_hs      <= HSYNC;
      r_hs_prev <= r_hs;
      r_vs      <= VSYNC;
      r_vs_prev <= r_vs;
    end
  end

  // Column/row counters and the per-frame bad-line flag.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_col       <= 10'd0;
      r_row       <= 9'd0;
      r_frame_bad <= 1'b0;
    end else begin
      r_col <= (IMG && (w_col_base != c_col_max)) ? w_col_base + 10'd1 : w_col_base;
      if (w_v_edge) begin
        r_row       <= 9'd0;
        r_frame_bad <= 1'b0;
      end else begin
        r_row <= w_row_closed;
        if (w_h_edge && w_line_bad) begin
          r_frame_bad <= 1'b1;
        end
      end
    end
  end

  // Pixel outputs and one-cycle pulses, one cycle after sampling.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      X           <= 10'd0;
      Y           <= 9'd0;
      pix_valid   <= 1'b0;
      r_out       <= 8'd0;
      g_out       <= 8'd0;
      b_out       <= 8'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      X           <= w_col_base;
      Y           <= w_v_edge ? 9'd0 : r_row;
      pix_valid   <= IMG;
      r_out       <= IMG ? r_in : 8'd0;
      g_out       <= IMG ? g_in : 8'd0;
      b_out       <= IMG ? b_in : 8'd0;
      line_start  <= w_h_edge;
      frame_start <= w_v_edge;
      sync_err    <= w_err;
    end
  end

  // Lock FSM state and good-frame counter registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_UNLOCKED;
      r_good_cnt <= 3'd0;
    end else begin
      r_state    <= w_state_next;
      r_good_cnt <= w_good_next;
    end
  end

  // Lock FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good_cnt;
    w_err        = 1'b0;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_v_edge) begin
          w_state_next = ST_MEASURE;
          w_good_next  = 3'd0;
        end
      end
      ST_MEASURE: begin
        if (w_v_edge) begin
          if (w_frame_bad) begin
            w_good_next = 3'd0;
          end else begin
            w_good_next = w_good_inc;
            if (w_good_inc >= c_lock_frames) begin
              w_state_next = ST_LOCKED;
            end
          end
        end
      end
      ST_LOCKED: begin
        if ((w_h_edge && w_line_bad) || (w_v_edge && w_frame_bad)) begin
          w_state_next = ST_UNLOCKED;
          w_good_next  = 3'd0;
          w_err        = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_UNLOCKED;
        w_good_next  = 3'd0;
      end
    endcase
  end

`ifdef VGA_DEC_MEASURE_EN
  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic       r_h_seen;
  logic       r_v_seen;
  logic [9:0] w_vcnt_closed;

  // The HSYNC edge coinciding with VSYNC closes the frame's last line.
  assign w_vcnt_closed = (w_h_edge && (r_vcnt != c_col_max)) ? r_vcnt + 10'd1 : r_vcnt;

  // Period measurement; totals only update once a previous edge exists.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_hcnt   <= 10'd0;
      r_vcnt   <= 10'd0;
      r_h_seen <= 1'b0;
      r_v_seen <= 1'b0;
      h_total  <= 10'd0;
      v_total  <= 10'd0;
    end else begin
      if (w_h_edge) begin
        r_hcnt   <= 10'd1;
        r_h_seen <= 1'b1;
        if (r_h_seen) begin
          h_total <= r_hcnt;
        end
      end else if (r_hcnt != c_col_max) begin
        r_hcnt <= r_hcnt + 10'd1;
      end
      if (w_v_edge) begin
        r_vcnt   <= 10'd0;
        r_v_seen <= 1'b1;
        if (r_v_seen) begin
          v_total <= w_vcnt_closed;
        end
      end else begin
        r_vcnt <= w_vcnt_closed;
      end
    end
  end
`else
  assign h_total = 10'd0;
  assign v_total = 10'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_decoder
// Description : Self-checking bench for vga_sync_decoder on a reduced raster
//               (8x4 active, 12 cycles/line, 7 lines/frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_decoder;

  localparam int HA = 8;
  localparam int VA = 4;
  localparam int HT = 12;
  localparam int VT = 7;

  logic       clk;
  logic       reset_n;
  logic       hsync, vsync, img;
  logic [7:0] r_in, g_in, b_in;
  logic [7:0] r_out, g_out, b_out;
  logic [9:0] X;
  logic [8:0] Y;
  logic       pix_valid, line_start, frame_start, locked, sync_err;
  logic [9:0] h_total, v_total;

  vga_sync_decoder #(.H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)) dut (
    .CLK(clk), .reset(reset_n), .HSYNC(hsync), .VSYNC(vsync), .IMG(img),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .X(X), .Y(Y), .pix_valid(pix_valid),
    .line_start(line_start), .frame_start(frame_start),
    .locked(locked), .sync_err(sync_err),
    .h_total(h_total), .v_total(v_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ls_cnt   = 0;
  int fs_cnt   = 0;
  int se_cnt   = 0;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (line_start)  ls_cnt++;
    if (frame_start) fs_cnt++;
    if (sync_err)    se_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-frame captures
  logic        lk_before, lk_after, fs_after, se_after;
  logic [9:0]  fx, lx;
  logic [8:0]  fy, ly;
  logic        fv, bv;
  logic [23:0] frgb, brgb;
  logic        lk_line [VT];
  logic        se_line [VT];

  // Drives lines l0..l1 of a frame: VSYNC low on lines 0-1 (falling with
  // HSYNC on line 0), nact active lines starting at line 2+shift, line
  // 'bad' carries HA-1 pixels.
  task automatic do_frame(input int nact, input int shift, input int bad,
                          input int l0, input int l1);
    int  first_act, last_act, npix, k;
    bit  act, im;
    first_act = 2 + shift;
    last_act  = first_act + nact - 1;
    for (int ln = l0; ln <= l1; ln++) begin
      act  = (ln >= first_act) && (ln <= last_act);
      npix = !act ? 0 : ((ln == bad) ? HA - 1 : HA);
      k    = 0;
      for (int c = 0; c < HT; c++) begin
        im    = (c >= 3) && (c < 3 + npix);
        hsync = (c < 2) ? 1'b0 : 1'b1;
        vsync = (ln < 2) ? 1'b0 : 1'b1;
        img   = im;
        if (im) {r_in, g_in, b_in} = (k == 0) ? 24'h123456 : {8'(k), 8'(k + 16), 8'(k + 32)};
        else    {r_in, g_in, b_in} = 24'hFFFFFF;
        tick();
        if (ln == 0 && c == 0) lk_before = locked;
        if (c == 1) begin
          lk_line[ln] = locked;
          se_line[ln] = sync_err;
          if (ln == 0) begin
            lk_after = locked;
            fs_after = frame_start;
            se_after = sync_err;
          end
        end
        if (ln == first_act && im && k == 0) begin
          fx = X; fy = Y; fv = pix_valid; frgb = {r_out, g_out, b_out};
        end
        if (ln == first_act && c == HT - 1) begin
          bv = pix_valid; brgb = {r_out, g_out, b_out};
        end
        if (ln == last_act && im && k == npix - 1) begin
          lx = X; ly = Y;
        end
        if (im) k++;
      end
    end
  endtask

  task automatic check_totals(input string tag);
`ifdef VGA_DEC_MEASURE_EN
    check({tag, "_h_total"}, 32'(h_total), HT);
    check({tag, "_v_total"}, 32'(v_total), VT);
`else
    check({tag, "_h_total"}, 32'(h_total), 0);
    check({tag, "_v_total"}, 32'(v_total), 0);
`endif
  endtask

  typedef struct {
    logic        im;
    logic [23:0] rgb;
    logic        exp_valid;
    logic [23:0] exp_rgb;
    logic [9:0]  exp_x;
  } vec_t;

  vec_t vecs [6];
  int   ls0, fs0, se0;

  initial begin
    vecs[0] = '{1'b1, 24'h123456, 1'b1, 24'h123456, 10'd0};
    vecs[1] = '{1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 10'd1};
    vecs[2] = '{1'b1, 24'hABCDEF, 1'b1, 24'hABCDEF, 10'd1};
    vecs[3] = '{1'b1, 24'h00FF80, 1'b1, 24'h00FF80, 10'd2};
    vecs[4] = '{1'b0, 24'h808080, 1'b0, 24'h000000, 10'd3};
    vecs[5] = '{1'b1, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 10'd3};

    // Reset held: outputs stay zero despite toggling inputs
    reset_n = 1'b0; hsync = 1'b1; vsync = 1'b1; img = 1'b1;
    {r_in, g_in, b_in} = 24'hA5A5A5;
    tick(); hsync = 1'b0; vsync = 1'b0; tick(); hsync = 1'b1; tick();
    check("rst_X", 32'(X), 0);
    check("rst_Y", 32'(Y), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_rgb", 32'({r_out, g_out, b_out}), 0);
    check("rst_line_start", 32'(line_start), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_sync_err", 32'(sync_err), 0);
    check_totals("rst");

    // Release with sync lines low: no edge may be seen on the first cycle
    hsync = 1'b0; vsync = 1'b0; img = 1'b0;
    reset_n = 1'b1;
    tick(); tick();
    check("first_cycle_line_start", 32'(line_start), 0);
    check("first_cycle_frame_start", 32'(frame_start), 0);
    hsync = 1'b1; vsync = 1'b1;

    // Table-driven pixel path
    for (int i = 0; i < 6; i++) begin
      img = vecs[i].im;
      {r_in, g_in, b_in} = vecs[i].rgb;
      tick();
      check($sformatf("vec%0d_pix_valid", i), 32'(pix_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_rgb", i), 32'({r_out, g_out, b_out}), 32'(vecs[i].exp_rgb));
      check($sformatf("vec%0d_X", i), 32'(X), 32'(vecs[i].exp_x));
    end
    check("vec_Y", 32'(Y), 0);

    // Lock acquisition: third VSYNC edge locks
    do_frame(VA, 0, -1, 0, VT - 1);
    check("A_frame_start", 32'(fs_after), 1);
    check("A_locked", 32'(lk_after), 0);
    do_frame(VA, 0, -1, 0, VT - 1);
    check("B_locked", 32'(lk_after), 0);
    ls0 = ls_cnt; fs0 = fs_cnt; se0 = se_cnt;
    do_frame(VA, 0, -1, 0, VT - 1);
    check("C_locked_before", 32'(lk_before), 0);
    check("C_locked_after", 32'(lk_after), 1);
    check("C_frame_start", 32'(fs_after), 1);
    check("C_line_starts", ls_cnt - ls0, VT);
    check("C_frame_starts", fs_cnt - fs0, 1);
    check("C_no_sync_err", se_cnt - se0, 0);
    check("C_first_X", 32'(fx), 0);
    check("C_first_Y", 32'(fy), 0);
    check("C_first_valid", 32'(fv), 1);
    check("C_first_rgb", 32'(frgb), 32'h123456);
    check("C_blank_valid", 32'(bv), 0);
    check("C_blank_rgb", 32'(brgb), 0);
    check("C_last_X", 32'(lx), HA - 1);
    check("C_last_Y", 32'(ly), VA - 1);
    check_totals("C");

    // Short line while locked: one sync_err, unlock, relock after 2 frames
    se0 = se_cnt;
    do_frame(VA, 0, 3, 0, VT - 1);
    check("D_locked_during_bad_line", 32'(lk_line[3]), 1);
    check("D_locked_after_close", 32'(lk_line[4]), 0);
    check("D_sync_err_pulse", 32'(se_line[4]), 1);
    do_frame(VA, 0, -1, 0, VT - 1);
    check("E_locked", 32'(lk_after), 0);
    check("DE_sync_err_count", se_cnt - se0, 1);
    do_frame(VA, 0, -1, 0, VT - 1);
    check("F_locked", 32'(lk_after), 0);
    do_frame(VA, 0, -1, 0, VT - 1);
    check("G_relocked", 32'(lk_after), 1);

    // Asynchronous reset mid-frame while locked
    do_frame(VA, 0, -1, 0, 3);
    check("H_locked_pre_reset", 32'(locked), 1);
    img = 1'b1; {r_in, g_in, b_in} = 24'hAABBCC;
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_X", 32'(X), 0);
    check("mid_rst_Y", 32'(Y), 0);
    check("mid_rst_pix_valid", 32'(pix_valid), 0);
    check("mid_rst_rgb", 32'({r_out, g_out, b_out}), 0);
    check("mid_rst_locked", 32'(locked), 0);
    tick(); tick();
    reset_n = 1'b1;
    img = 1'b0;
    do_frame(VA, 0, -1, 4, VT - 1);
    // Frames whose last active line closes on the coincident edge
    do_frame(VA, 1, -1, 0, VT - 1);
    check("a_locked", 32'(lk_after), 0);
    do_frame(VA, 1, -1, 0, VT - 1);
    check("b_locked", 32'(lk_after), 0);
    check("b_first_Y", 32'(fy), 0);
    check("b_last_Y", 32'(ly), VA - 1);
    // Locked, then a frame one active line short
    do_frame(VA - 1, 0, -1, 0, VT - 1);
    check("c_locked", 32'(lk_after), 1);
    do_frame(VA, 0, -1, 0, VT - 1);
    check("d_locked_before", 32'(lk_before), 1);
    check("d_locked_after", 32'(lk_after), 0);
    check("d_sync_err", 32'(se_after), 1);

    // Short frame during MEASURE clears the good-frame count
    do_frame(VA, 0, -1, 0, VT - 1);
    check("e_locked", 32'(lk_after), 0);
    do_frame(VA - 1, 0, -1, 0, VT - 1);
    check("f_locked", 32'(lk_after), 0);
    do_frame(VA, 0, -1, 0, VT - 1);
    check("g_locked", 32'(lk_after), 0);
    do_frame(VA, 0, -1, 0, VT - 1);
    check("h_locked", 32'(lk_after), 0);
    do_frame(VA, 0, -1, 0, VT - 1);
    check("i_locked", 32'(lk_after), 1);
    check_totals("i");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
